reorder_tag_issuer: RTL

- Initiator-side companion to the in-order reorder queue.
- Accepts in-order memory requests and stamps each with a sequential tag {wrap bit, index}, then issues them to the memory port.
- Tracks outstanding requests as credits, so no more than DEPTH requests are ever in flight. Retire pulses from the reorder queue output return credits.
- Provides a post-reset init window and a drain handshake.

---
 rtl/reorder_tag_issuer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/reorder_tag_issuer.sv
// reorder_tag_issuer: stamps in-order memory requests with a sequential
// {wrap, index} tag, issues them through a single output register and
// limits the number of requests in flight to DEPTH using retire credits.
module reorder_tag_issuer #(
    parameter int ADDR_WIDTH = 48,
    parameter int DEPTH      = 32,
    parameter int IDX_WIDTH  = $clog2(DEPTH),
    parameter int TAG_WIDTH  = IDX_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [TAG_WIDTH-1:0]  mem_tag,
    input  logic                  mem_stall,
    input  logic                  retire,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [TAG_WIDTH-1:0]  outstanding,
    output logic                  retire_err
);

    localparam logic [TAG_WIDTH-1:0] LP_DEPTH     = TAG_WIDTH'(DEPTH);
    localparam logic [IDX_WIDTH-1:0] LP_INIT_LAST = IDX_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_WIDTH-1:0]    r_init_cnt;
    logic [TAG_WIDTH-1:0]    r_tag_cnt;
    logic [TAG_WIDTH-1:0]    r_outstanding;
    logic                    r_vld_p1;
    logic [ADDR_WIDTH-1:0]   r_addr_p1;
    logic [TAG_WIDTH-1:0]    r_tag_p1;
    logic                    r_drain_done;
    logic                    r_retire_err;

    logic                    w_fire;
    logic                    w_accept;
    logic                    w_retire_ok;
    logic                    w_drain_cond;

    // The output register frees up when empty or when its beat leaves this cycle.
    assign w_fire       = r_vld_p1 && !mem_stall;
    assign req_ready    = (r_state == S_RUN) && (r_outstanding < LP_DEPTH) &&
                          (!r_vld_p1 || !mem_stall);
    assign w_accept     = req_valid && req_ready;
    // A retire with nothing outstanding is an error and must not underflow.
    assign w_retire_ok  = retire && (r_outstanding != '0);
    assign w_drain_cond = (r_outstanding == '0) && !r_vld_p1;

    assign mem_valid    = r_vld_p1;
    assign mem_addr     = r_addr_p1;
    assign mem_tag      = r_tag_p1;
    assign drain_done   = r_drain_done;
    assign outstanding  = r_outstanding;
    assign retire_err   = r_retire_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_state_nxt;
    end

    // Next-state: INIT lasts DEPTH cycles, RUN issues, DRAIN waits for credits.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_init_cnt == LP_INIT_LAST) w_state_nxt = S_RUN;
            S_RUN:   if (drain_req)                  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_cond)               w_state_nxt = S_RUN;
            default:                                 w_state_nxt = S_INIT;
        endcase
    end

    // Init-window counter, only advances while in INIT.
    always_ff @(posedge clk) begin
        if (rst)                    r_init_cnt <= '0;
        else if (r_state == S_INIT) r_init_cnt <= r_init_cnt + IDX_WIDTH'(1);
    end

    // Tag counter wraps modulo 2*DEPTH; drain leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst)           r_tag_cnt <= '0;
        else if (w_accept) r_tag_cnt <= r_tag_cnt + TAG_WIDTH'(1);
    end

    // Credit count includes the beat sitting in the output register.
    always_ff @(posedge clk) begin
        if (rst) r_outstanding <= '0;
        else     r_outstanding <= r_outstanding + TAG_WIDTH'(w_accept) - TAG_WIDTH'(w_retire_ok);
    end

    // ---- output stage p1: load on accept, clear on fire, hold on stall ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_addr_p1 <= '0;
            r_tag_p1  <= '0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_addr_p1 <= req_addr;
            r_tag_p1  <= r_tag_cnt;
        end else if (w_fire) begin
            r_vld_p1  <= 1'b0;
        end
    end

    // Drain completion pulse and sticky retire-underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_done <= 1'b0;
            r_retire_err <= 1'b0;
        end else begin
            r_drain_done <= (r_state == S_DRAIN) && w_drain_cond;
            if (retire && (r_outstanding == '0)) r_retire_err <= 1'b1;
        end
    end

endmodule
